mips_main_control: RTL and testbench
====================================

# mips_main_control

Multicycle MIPS main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps. It sits directly upstream of the ALU control decoder and drives it through the 2-bit `aluOp` code: 00 = add (address and PC arithmetic), 01 = subtract (branch compare), 10 = decode `funct`. It also drives every datapath mux and write strobe, and waits on a memory-ready handshake.

## Interface
- `CNT_WIDTH`, 16, width of the retired-instruction counter.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]. Stable from DECODE until the instruction's last state.
- `memReady` in 1: memory has completed the current access this cycle.
- `aluOp` out 2: to the ALU control decoder.
- `aluSrcA` out 1: 0 = PC, 1 = register A.
- `aluSrcB` out 2: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pcSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `iorD`, `memRead`, `memWrite`, `irWrite`, `regDst`, `memToReg`, `regWrite`, `pcWrite`, `branchEq`, `branchNe` out 1 each: datapath controls.
- `illegalOp` out 1: unsupported opcode trapped.
- `state` out 4: current state, for debug.
- `retired` out `CNT_WIDTH`: count of completed instructions.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, ILLEGAL 12.
- All outputs not listed for a state are 0.
- **FETCH**
  - Outputs: memRead=1, aluSrcB=01, aluOp=00, pcSource=00, irWrite=memReady, pcWrite=memReady. The two gated strobes are a combinational function of `memReady`.
  - Next: DECODE if `memReady`, else stay in FETCH.
- **DECODE**
  - Outputs: aluSrcB=11, aluOp=00.
  - Latches `opcode` into an internal opReg.
  - Next: 0x00 → EXEC; 0x23 or 0x2B → MEMADR; 0x04 or 0x05 → BRANCH; 0x02 → JUMP; 0x08 → ADDIEX; any other value → ILLEGAL.
- **MEMADR**: aluSrcA=1, aluSrcB=10, aluOp=00. Next: MEMRD if opReg=0x23, else MEMWR.
- **MEMRD**: memRead=1, iorD=1. Next: MEMWB when `memReady`, else stay.
- **MEMWB**: regWrite=1, memToReg=1, regDst=0. Next: FETCH.
- **MEMWR**: memWrite=1, iorD=1. Next: FETCH when `memReady`, else stay.
- **EXEC**: aluSrcA=1, aluSrcB=00, aluOp=10. Next: ALUWB.
- **ALUWB**: regWrite=1, regDst=1, memToReg=0. Next: FETCH.
- **BRANCH**
  - Outputs: aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=01.
  - branchEq=1 if opReg=0x04; branchNe=1 if opReg=0x05; never both.
  - Next: FETCH.
- **JUMP**: pcSource=10, pcWrite=1. Next: FETCH.
- **ADDIEX**: aluSrcA=1, aluSrcB=10, aluOp=00. Next: ADDIWB.
- **ADDIWB**: regWrite=1, regDst=0, memToReg=0. Next: FETCH.
- **ILLEGAL**: illegalOp=1, all strobes 0. Stays in ILLEGAL until reset.
- Encodings 13–15 are unreachable. If entered: all outputs 0, next state FETCH, `retired` not incremented.
- **`retired` counter**
  - Increments by 1 on every clock edge that leaves MEMWB, ALUWB, BRANCH, JUMP or ADDIWB, or that leaves MEMWR with `memReady`=1.
  - Unsigned; wraps from 2^CNT_WIDTH−1 to 0 with no flag.

## Timing
- Reset (`reset_n`=0, asynchronous)
  - state = FETCH, opReg = 0, `retired` = 0.
  - All outputs forced to 0 while `reset_n` is low, including memRead, irWrite, pcWrite and illegalOp; `state` reads 0.
  - Reset asserted mid-instruction (for example during MEMWR) aborts the instruction immediately: memWrite drops in the same cycle and no count is recorded.
- First rising edge after `reset_n` releases: operation continues from FETCH with normal outputs.
- Latency with `memReady` held at 1:
  - R-type: 4 cycles. addi: 4 cycles.
  - lw: 5 cycles. sw: 4 cycles.
  - beq/bne: 3 cycles. j: 3 cycles.
- Each cycle with `memReady`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle; outputs are held constant while waiting.
- `memReady` is ignored in every other state.

## Test plan
- R-type (opcode 0x00, `memReady`=1): state sequence 0,1,6,7,0; aluOp=10 only in EXEC; regWrite=1 with regDst=1 in ALUWB; `retired` 0→1.
- lw (0x23) with `memReady` low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0 (7 cycles); iorD=1 throughout MEMRD; memToReg=1 in MEMWB.
- beq (0x04) then bne (0x05): in BRANCH, aluOp=01, pcSource=01, branchEq=1/branchNe=0 for beq, then branchEq=0/branchNe=1 for bne; `retired`=2.
- Illegal opcode 0x3F: DECODE → ILLEGAL; illegalOp=1 held for 10+ cycles with no strobes and `retired` frozen; pulsing `reset_n` low returns to FETCH with illegalOp=0.
- Reset asserted during MEMWR: memWrite goes to 0 without waiting for a clock edge; after release, state=0 and `retired`=0.
- With CNT_WIDTH=4, 17 consecutive j (0x02) instructions: `retired` reads 15 after the 15th, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: Moore FSM that steps each instruction through
// fetch/decode/execute/memory/write-back and counts retired instructions.
module mips_main_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [5:0]           opcode,
  input  logic                 memReady,
  output logic [1:0]           aluOp,
  output logic                 aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [1:0]           pcSource,
  output logic                 iorD,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic                 regDst,
  output logic                 memToReg,
  output logic                 regWrite,
  output logic                 pcWrite,
  output logic                 branchEq,
  output logic                 branchNe,
  output logic                 illegalOp,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           op_reg_q, op_reg_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 retire;

  logic [1:0] alu_op_c, alu_src_b_c, pc_source_c;
  logic       alu_src_a_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, pc_write_c;
  logic       branch_eq_c, branch_ne_c, illegal_op_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      op_reg_q  <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_reg_q  <= op_reg_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_reg_d     = op_reg_q;
    retire       = 1'b0;
    alu_op_c     = 2'b00;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    pc_source_c  = 2'b00;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    pc_write_c   = 1'b0;
    branch_eq_c  = 1'b0;
    branch_ne_c  = 1'b0;
    illegal_op_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = memReady;
        pc_write_c  = memReady;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        op_reg_d    = opcode;
        case (opcode)
          6'h00:        state_d = S_EXEC;
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          6'h08:        state_d = S_ADDIEX;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else state_d = (op_reg_q == 6'h23) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (memReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_source_c = 2'b01;
        branch_eq_c = (op_reg_q == 6'h04);
        branch_ne_c = (op_reg_q == 6'h05);
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_source_c = 2'b10;
        pc_write_c  = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ILLEGAL: illegal_op_c = 1'b1;
      // Encodings 13-15: recover to FETCH silently.
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + CNT_WIDTH'(1) : retired_q;
  end

  // Every control is held low while reset is asserted, without waiting for a clock.
  assign aluOp     = reset_n ? alu_op_c    : 2'b00;
  assign aluSrcB   = reset_n ? alu_src_b_c : 2'b00;
  assign pcSource  = reset_n ? pc_source_c : 2'b00;
  assign aluSrcA   = reset_n & alu_src_a_c;
  assign iorD      = reset_n & iord_c;
  assign memRead   = reset_n & mem_read_c;
  assign memWrite  = reset_n & mem_write_c;
  assign irWrite   = reset_n & ir_write_c;
  assign regDst    = reset_n & reg_dst_c;
  assign memToReg  = reset_n & mem_to_reg_c;
  assign regWrite  = reset_n & reg_write_c;
  assign pcWrite   = reset_n & pc_write_c;
  assign branchEq  = reset_n & branch_eq_c;
  assign branchNe  = reset_n & branch_ne_c;
  assign illegalOp = reset_n & illegal_op_c;
  assign state     = reset_n ? state_q : 4'd0;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mips_main_control.sv
// Directed bench for mips_main_control: walks each instruction class through
// its state sequence and compares every control output against hand tables.
module tb_mips_main_control;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [5:0]    opcode;
  logic          memReady;
  logic [1:0]    aluOp, aluSrcB, pcSource;
  logic          aluSrcA, iorD, memRead, memWrite, irWrite, regDst, memToReg;
  logic          regWrite, pcWrite, branchEq, branchNe, illegalOp;
  logic [3:0]    state;
  logic [CW-1:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  // {aluOp, aluSrcA, aluSrcB, pcSource, iorD, memRead, memWrite, irWrite,
  //  regDst, memToReg, regWrite, pcWrite, branchEq, branchNe, illegalOp}
  logic [17:0] ctrl;
  assign ctrl = {aluOp, aluSrcA, aluSrcB, pcSource, iorD, memRead, memWrite, irWrite,
                 regDst, memToReg, regWrite, pcWrite, branchEq, branchNe, illegalOp};

  localparam logic [17:0] E_ZERO   = 18'b00_0_00_00_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] E_FETCH1 = 18'b00_0_01_00_0_1_0_1_0_0_0_1_0_0_0;
  localparam logic [17:0] E_FETCH0 = 18'b00_0_01_00_0_1_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] E_DECODE = 18'b00_0_11_00_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] E_MEMADR = 18'b00_1_10_00_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] E_MEMRD  = 18'b00_0_00_00_1_1_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] E_MEMWB  = 18'b00_0_00_00_0_0_0_0_0_1_1_0_0_0_0;
  localparam logic [17:0] E_MEMWR  = 18'b00_0_00_00_1_0_1_0_0_0_0_0_0_0_0;
  localparam logic [17:0] E_EXEC   = 18'b10_1_00_00_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] E_ALUWB  = 18'b00_0_00_00_0_0_0_0_1_0_1_0_0_0_0;
  localparam logic [17:0] E_BEQ    = 18'b01_1_00_01_0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [17:0] E_BNE    = 18'b01_1_00_01_0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [17:0] E_JUMP   = 18'b00_0_00_10_0_0_0_0_0_0_0_1_0_0_0;
  localparam logic [17:0] E_ADDIWB = 18'b00_0_00_00_0_0_0_0_0_0_1_0_0_0_0;
  localparam logic [17:0] E_ILL    = 18'b00_0_00_00_0_0_0_0_0_0_0_0_0_0_1;

  mips_main_control #(.CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .memReady(memReady),
    .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
    .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite), .pcWrite(pcWrite),
    .branchEq(branchEq), .branchNe(branchNe), .illegalOp(illegalOp),
    .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive memReady, check the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic mr, input logic [3:0] exp_state,
                     input logic [17:0] exp_ctrl, input logic [CW-1:0] exp_ret);
    memReady = mr;
    #1;
    check({tag, "_state"}, 32'(state), 32'(exp_state));
    check({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
    check({tag, "_retired"}, 32'(retired), 32'(exp_ret));
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset_n  = 1'b0;
    memReady = 1'b1;
    opcode   = 6'h00;
    #3;
    check("reset_ctrl", 32'(ctrl), 32'(E_ZERO));
    check("reset_state", 32'(state), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;

    // R-type
    opcode = 6'h00;
    cyc("r_fetch", 1, 4'd0, E_FETCH1, 0);
    cyc("r_decode", 1, 4'd1, E_DECODE, 0);
    cyc("r_exec", 1, 4'd6, E_EXEC, 0);
    cyc("r_aluwb", 1, 4'd7, E_ALUWB, 0);

    // lw with two memory wait cycles in MEMRD
    opcode = 6'h23;
    cyc("lw_fetch", 1, 4'd0, E_FETCH1, 1);
    cyc("lw_decode", 1, 4'd1, E_DECODE, 1);
    cyc("lw_memadr", 1, 4'd2, E_MEMADR, 1);
    cyc("lw_memrd_w1", 0, 4'd3, E_MEMRD, 1);
    cyc("lw_memrd_w2", 0, 4'd3, E_MEMRD, 1);
    cyc("lw_memrd", 1, 4'd3, E_MEMRD, 1);
    cyc("lw_memwb", 1, 4'd4, E_MEMWB, 1);

    // addi with one wait cycle in FETCH
    opcode = 6'h08;
    cyc("addi_fetch_w", 0, 4'd0, E_FETCH0, 2);
    cyc("addi_fetch", 1, 4'd0, E_FETCH1, 2);
    cyc("addi_decode", 1, 4'd1, E_DECODE, 2);
    cyc("addi_ex", 0, 4'd10, E_MEMADR, 2);
    cyc("addi_wb", 0, 4'd11, E_ADDIWB, 2);

    // sw with one wait cycle in MEMWR
    opcode = 6'h2B;
    cyc("sw_fetch", 1, 4'd0, E_FETCH1, 3);
    cyc("sw_decode", 1, 4'd1, E_DECODE, 3);
    cyc("sw_memadr", 1, 4'd2, E_MEMADR, 3);
    cyc("sw_memwr_w", 0, 4'd5, E_MEMWR, 3);
    cyc("sw_memwr", 1, 4'd5, E_MEMWR, 3);

    // beq then bne
    opcode = 6'h04;
    cyc("beq_fetch", 1, 4'd0, E_FETCH1, 4);
    cyc("beq_decode", 1, 4'd1, E_DECODE, 4);
    cyc("beq_branch", 1, 4'd8, E_BEQ, 4);
    opcode = 6'h05;
    cyc("bne_fetch", 1, 4'd0, E_FETCH1, 5);
    cyc("bne_decode", 1, 4'd1, E_DECODE, 5);
    cyc("bne_branch", 1, 4'd8, E_BNE, 5);
    check("after_branches_retired", 32'(retired), 32'd6);

    // Reset asserted in MEMWR aborts without a clock edge
    opcode = 6'h2B;
    cyc("swr_fetch", 1, 4'd0, E_FETCH1, 6);
    cyc("swr_decode", 1, 4'd1, E_DECODE, 6);
    cyc("swr_memadr", 1, 4'd2, E_MEMADR, 6);
    memReady = 1'b0;
    #1;
    check("swr_memwr_ctrl", 32'(ctrl), 32'(E_MEMWR));
    reset_n = 1'b0;
    #1;
    check("swr_abort_memwrite", 32'(memWrite), 32'd0);
    check("swr_abort_ctrl", 32'(ctrl), 32'(E_ZERO));
    check("swr_abort_state", 32'(state), 32'd0);
    check("swr_abort_retired", 32'(retired), 32'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;

    // 17 jumps with a 4-bit counter: 15, then wrap to 0, then 1
    opcode = 6'h02;
    for (int k = 1; k <= 17; k++) begin
      cyc("j_fetch", 1, 4'd0, E_FETCH1, CW'(k - 1));
      cyc("j_decode", 1, 4'd1, E_DECODE, CW'(k - 1));
      cyc("j_jump", 1, 4'd9, E_JUMP, CW'(k - 1));
      check("j_retired_after", 32'(retired), 32'(k % 16));
    end

    // Illegal opcode traps until reset; memReady is ignored there
    opcode = 6'h3F;
    cyc("ill_fetch", 1, 4'd0, E_FETCH1, 1);
    cyc("ill_decode", 1, 4'd1, E_DECODE, 1);
    for (int k = 0; k < 12; k++) begin
      cyc("ill_hold", 1'($urandom_range(0, 1)), 4'd12, E_ILL, 1);
    end
    reset_n = 1'b0;
    #1;
    check("ill_reset_ctrl", 32'(ctrl), 32'(E_ZERO));
    check("ill_reset_state", 32'(state), 32'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    opcode = 6'h00;
    cyc("post_ill_fetch", 1, 4'd0, E_FETCH1, 0);
    cyc("post_ill_decode", 1, 4'd1, E_DECODE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
